fp_div: RTL and testbench

- IEEE-754 binary32 divider using Goldschmidt iteration, with a remainder-based correction step and selectable rounding (RNE/RZ).
- Free-running: no start/done handshake. It repeatedly samples its operands, computes, and updates a registered quotient once per fixed-length operation window.
- Sits in the FP execute datapath. The surrounding logic holds the operands stable across each window.

---
 rtl/fp_div_pkg.sv | 25 ++
 rtl/fp_div_round.sv | 68 ++++++
 rtl/fp_div.sv | 145 ++++++++++++++
 tb/tb_fp_div.sv | 105 ++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the binary32 Goldschmidt divider.
package fp_div_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef enum logic { RNE = 1'b0, RZ = 1'b1 } rmode_e;
   typedef enum logic [1:0] { OP_DIV = 2'b00, OP_SQRT = 2'b01 } op_e;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] INF  = 32'h7F80_0000;
   localparam logic [31:0] MAXF = 32'h7F7F_FFFF;
   localparam int          BIAS = 127;

   // Leading zeros of a 24-bit mantissa; 24 for an all-zero input.
   function automatic logic [4:0] lzc24(input logic [23:0] m);
      lzc24 = 5'd24;
      for (int i = 0; i < 24; i++)
         if (m[i]) lzc24 = 5'(23 - i);
   endfunction

endpackage

// File: rtl/fp_div_round.sv
// Normalize, subnormal denormalize, RNE/RZ round and pack a 27-bit quotient.
// Rounding registered when i_en is high; the packed result is combinational from that stage.
module fp_div_round
   import fp_div_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_en,
   input  logic              i_sign,
   input  logic signed [9:0] i_exp,
   input  logic [26:0]       i_q,
   input  logic              i_sticky,
   input  logic              i_rz,
   output logic [31:0]       o_result
);

   logic [26:0]       w_m;
   logic signed [9:0] w_e;
   logic              w_sub;
   logic              w_ovf;
   logic [4:0]        w_sh;
   logic [58:0]       w_wide;
   logic [26:0]       w_ms;
   logic              w_st;
   logic              w_inc;
   logic [30:0]       w_base;

   logic              r_sign;
   logic              r_ovf;
   logic              r_rz;
   logic [30:0]       r_mag;

   // i_q is q * 2^26 with q in [0.5, 2); bring it to [1, 2).
   assign w_m   = i_q[26] ? i_q : {i_q[25:0], 1'b0};
   assign w_e   = i_q[26] ? i_exp : i_exp - 10'sd1;
   assign w_ovf = (w_e >= 10'sd255);
   assign w_sub = (w_e <= 10'sd0);

   always_comb begin
      w_sh = 5'd0;
      if (w_sub)
         w_sh = (w_e < -10'sd30) ? 5'd31 : 5'(10'sd1 - w_e);
   end

   assign w_wide = {w_m, 32'b0} >> w_sh;
   assign w_ms   = w_wide[58:32];
   assign w_st   = (|w_ms[1:0]) | (|w_wide[31:0]) | i_sticky;
   assign w_inc  = !i_rz & w_ms[2] & (w_st | w_ms[3]);
   // Hidden bit survives only for normal results, so it gates the exponent field.
   assign w_base = {w_e[7:0] & {8{w_ms[26]}}, w_ms[25:3]};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sign <= 1'b0;
         r_ovf  <= 1'b0;
         r_rz   <= 1'b0;
         r_mag  <= '0;
      end else if (i_en) begin
         r_sign <= i_sign;
         r_ovf  <= w_ovf;
         r_rz   <= i_rz;
         r_mag  <= w_base + 31'(w_inc);
      end
   end

   assign o_result = r_ovf ? ((r_rz ? MAXF : INF) | {r_sign, 31'b0}) : {r_sign, r_mag};

endmodule

// File: rtl/fp_div.sv
// Free-running binary32 divider: Goldschmidt iterations on one shared multiplier, remainder fix-up.
// Operands sampled at cnt 0; quotient updates every WIN cycles and holds for the whole next window.
module fp_div
   import fp_div_pkg::*;
#(
   parameter int ITER = 5,
   parameter int WIN  = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        round_mode,
   input  logic [1:0]  op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient
);

   localparam int CW = $clog2(WIN);
   localparam int FB = 32;
   localparam int GW = FB + 2;
   localparam int QW = 27;
   localparam logic [CW-1:0] C_ITER_END = CW'(2 * ITER);
   localparam logic [CW-1:0] C_REM      = CW'(2 * ITER + 1);
   localparam logic [CW-1:0] C_RND      = CW'(2 * ITER + 2);
   localparam logic [CW-1:0] C_PACK     = CW'(WIN - 1);
   localparam logic [GW-1:0] TWO        = {2'b10, {FB{1'b0}}};
   localparam logic [GW-1:0] QBIAS      = GW'(1) << (FB - 27);

   fp32_t             w_n, w_d;
   logic [23:0]       w_mn_raw, w_md_raw, w_mn, w_md;
   logic [4:0]        w_lz_n, w_lz_d;
   logic signed [9:0] w_en, w_ed, w_exp;
   logic              w_n_nan, w_n_inf, w_n_zero, w_d_nan, w_d_inf, w_d_zero;
   logic              w_sign, w_spec_vld;
   logic [31:0]       w_spec_val;
   logic [GW-1:0]     w_k, w_mul_a, w_prod_t;
   logic [QW-1:0]     w_q0;
   logic [QW+23:0]    w_qm;
   logic signed [52:0] w_rem;
   logic [31:0]       w_rnd;

   logic [CW-1:0]     r_cnt;
   logic              r_sign, r_rz, r_spec_vld, r_sticky;
   logic [31:0]       r_spec_val;
   logic signed [9:0] r_exp;
   logic [23:0]       r_mn, r_md;
   logic [GW-1:0]     r_n, r_d;
   logic [QW-1:0]     r_q;

   assign w_n = dividend;
   assign w_d = divisor;

   assign w_mn_raw = {|w_n.exp, w_n.frac};
   assign w_md_raw = {|w_d.exp, w_d.frac};
   assign w_lz_n   = lzc24(w_mn_raw);
   assign w_lz_d   = lzc24(w_md_raw);
   assign w_mn     = w_mn_raw << w_lz_n;
   assign w_md     = w_md_raw << w_lz_d;
   assign w_en     = ((w_n.exp == 8'd0) ? 10'sd1 : $signed({2'b0, w_n.exp})) - $signed({5'b0, w_lz_n});
   assign w_ed     = ((w_d.exp == 8'd0) ? 10'sd1 : $signed({2'b0, w_d.exp})) - $signed({5'b0, w_lz_d});
   assign w_exp    = w_en - w_ed + $signed(10'(BIAS));

   assign w_n_nan  = (&w_n.exp) & (|w_n.frac);
   assign w_n_inf  = (&w_n.exp) & ~(|w_n.frac);
   assign w_n_zero = (w_n.exp == 8'd0) & ~(|w_n.frac);
   assign w_d_nan  = (&w_d.exp) & (|w_d.frac);
   assign w_d_inf  = (&w_d.exp) & ~(|w_d.frac);
   assign w_d_zero = (w_d.exp == 8'd0) & ~(|w_d.frac);
   assign w_sign   = w_n.sign ^ w_d.sign;

   always_comb begin
      w_spec_vld = 1'b1;
      w_spec_val = QNAN;
      if ((op != OP_DIV) || w_n_nan || w_d_nan || (w_n_zero && w_d_zero) || (w_n_inf && w_d_inf))
         w_spec_val = QNAN;
      else if (w_d_zero || w_n_inf)
         w_spec_val = INF | {w_sign, 31'b0};
      else if (w_n_zero || w_d_inf)
         w_spec_val = {w_sign, 31'b0};
      else
         w_spec_vld = 1'b0;
   end

   // Odd cycles advance n, even cycles advance d; d is untouched between, so both see the same k.
   assign w_k      = TWO - r_d;
   assign w_mul_a  = r_cnt[0] ? r_n : r_d;
   assign w_prod_t = GW'(({{GW{1'b0}}, w_mul_a} * {{GW{1'b0}}, w_k}) >> FB);

   // Half-ulp bias makes the truncated estimate either exact or one ulp high, never low.
   assign w_q0  = QW'((r_n + QBIAS) >> (FB - 26));
   assign w_qm  = {{24{1'b0}}, w_q0} * {{QW{1'b0}}, r_md};
   assign w_rem = $signed({3'b0, r_mn, 26'b0}) - $signed({2'b0, w_qm});

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_rz       <= 1'b0;
         r_spec_vld <= 1'b0;
         r_spec_val <= '0;
         r_exp      <= '0;
         r_mn       <= '0;
         r_md       <= '0;
         r_n        <= '0;
         r_d        <= '0;
         r_q        <= '0;
         r_sticky   <= 1'b0;
         quotient   <= '0;
      end else begin
         r_cnt <= (r_cnt == C_PACK) ? '0 : r_cnt + CW'(1);
         if (r_cnt == '0) begin
            r_sign     <= w_sign;
            r_rz       <= (round_mode == RZ);
            r_spec_vld <= w_spec_vld;
            r_spec_val <= w_spec_val;
            r_exp      <= w_exp;
            r_mn       <= w_mn;
            r_md       <= w_md;
            r_n        <= {2'b0, w_mn, 8'b0};
            r_d        <= {2'b0, w_md, 8'b0};
         end else if (r_cnt <= C_ITER_END) begin
            if (r_cnt[0]) r_n <= w_prod_t;
            else          r_d <= w_prod_t;
         end else if (r_cnt == C_REM) begin
            r_q      <= w_rem[52] ? w_q0 - QW'(1) : w_q0;
            r_sticky <= |w_rem;
         end
         if (r_cnt == C_PACK)
            quotient <= r_spec_vld ? r_spec_val : w_rnd;
      end
   end

   fp_div_round u_round (
      .clk      (clk),
      .reset    (reset),
      .i_en     (r_cnt == C_RND),
      .i_sign   (r_sign),
      .i_exp    (r_exp),
      .i_q      (r_q),
      .i_sticky (r_sticky),
      .i_rz     (r_rz),
      .o_result (w_rnd)
   );

endmodule

// File: tb/tb_fp_div.sv
// Directed-vector bench for fp_div: reset, arithmetic, specials, range limits, mid-window abort.
module tb_fp_div;

   logic        clk = 1'b0;
   logic        reset;
   logic        round_mode;
   logic [1:0]  op;
   logic [31:0] dividend, divisor, quotient;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] prev;

   always #5 clk = ~clk;

   fp_div dut (
      .clk        (clk),
      .reset      (reset),
      .round_mode (round_mode),
      .op         (op),
      .dividend   (dividend),
      .divisor    (divisor),
      .quotient   (quotient)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv)
      else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, got, expv);
      end
   endtask

   // Called #1 after an edge that precedes a sampling edge; returns at the same phase.
   task automatic window(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic rm, input logic [1:0] o, input logic [31:0] expv);
      dividend   = a;
      divisor    = b;
      round_mode = rm;
      op         = o;
      repeat (7) @(posedge clk);
      #1;
      check({tag, "_hold"}, quotient, prev);
      dividend   = ~a;
      divisor    = ~b;
      round_mode = ~rm;
      op         = ~o;
      repeat (7) @(posedge clk);
      #1;
      check(tag, quotient, expv);
      prev = expv;
   endtask

   initial begin
      reset      = 1'b0;
      round_mode = 1'b0;
      op         = 2'b00;
      dividend   = 32'h3F80_0000;
      divisor    = 32'h3F80_0000;
      prev       = 32'h0;

      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         check("reset_q", quotient, 32'h0000_0000);
      end
      reset = 1'b1;

      window("one_div_one",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 2'b00, 32'h3F80_0000);
      window("three_half",    32'h4040_0000, 32'h4000_0000, 1'b0, 2'b00, 32'h3FC0_0000);
      window("five_half",     32'h40A0_0000, 32'h4000_0000, 1'b0, 2'b00, 32'h4020_0000);
      window("third_rne",     32'h3F80_0000, 32'h4040_0000, 1'b0, 2'b00, 32'h3EAA_AAAB);
      window("third_rz",      32'h3F80_0000, 32'h4040_0000, 1'b1, 2'b00, 32'h3EAA_AAAA);
      window("neg6_div_2",    32'hC0C0_0000, 32'h4000_0000, 1'b0, 2'b00, 32'hC040_0000);
      window("x_div_zero",    32'h3F80_0000, 32'h0000_0000, 1'b0, 2'b00, 32'h7F80_0000);
      window("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 2'b00, 32'h7FC0_0000);
      window("neg_div_inf",   32'hBF80_0000, 32'h7F80_0000, 1'b0, 2'b00, 32'h8000_0000);
      window("nan_in",        32'h7FC0_0000, 32'h3F80_0000, 1'b0, 2'b00, 32'h7FC0_0000);
      window("ovf_rne",       32'h7F7F_FFFF, 32'h3F00_0000, 1'b0, 2'b00, 32'h7F80_0000);
      window("ovf_rz",        32'h7F7F_FFFF, 32'h3F00_0000, 1'b1, 2'b00, 32'h7F7F_FFFF);
      window("sub_result",    32'h0080_0000, 32'h4000_0000, 1'b0, 2'b00, 32'h0040_0000);
      window("sub_input",     32'h0000_0001, 32'h3F00_0000, 1'b0, 2'b00, 32'h0000_0002);
      window("bad_op",        32'h3F80_0000, 32'h3F80_0000, 1'b0, 2'b01, 32'h7FC0_0000);

      dividend   = 32'h40A0_0000;
      divisor    = 32'h4000_0000;
      round_mode = 1'b0;
      op         = 2'b00;
      repeat (6) @(posedge clk);
      #1;
      check("pre_abort", quotient, prev);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort_q", quotient, 32'h0000_0000);
      reset = 1'b1;
      prev  = 32'h0;
      window("after_abort",   32'h40A0_0000, 32'h4000_0000, 1'b0, 2'b00, 32'h4020_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
